phy_tx: RTL and testbench

- Two-lane transmit serializer that drives the D_0/D_1 serial lanes consumed by the receive PHY.
- On enable it first sends a burst of COM (0xBC) symbols so the receiver can lock. It then serializes parallel bytes, MSB first, one bit per clk.
- A lane with no data offered sends IDLE (0x7C).
- Sits between the byte-level TX datapath and the serial link.

---
 rtl/phy_tx.sv | 152 +++++++++++++++
 tb/tb_phy_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx.sv
// phy_tx: two-lane transmit serializer.
// After enable it sends SYNC_COUNT COM symbols on both lanes so the receiver
// can lock, then serializes one byte per lane every 8 clocks, MSB first.
// A lane with no valid byte at a byte boundary sends the IDLE symbol instead.
// The serial outputs are the MSBs of the per-lane shift registers, so they
// are registered.
module phy_tx #(
  parameter int unsigned SYNC_COUNT = 4,
  parameter logic [7:0]  COM        = 8'hBC,
  parameter logic [7:0]  IDLE       = 8'h7C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in_0,
  input  logic       valid_in_0,
  input  logic [7:0] data_in_1,
  input  logic       valid_in_1,
  output logic       ready,
  output logic       active,
  output logic       D_0,
  output logic       D_1
);

  // Wide enough to count up to SYNC_COUNT, which is reached on the last
  // COM boundary as the link moves to ACTIVE.
  localparam int unsigned SYNC_W = $clog2(SYNC_COUNT + 1);
  localparam logic [SYNC_W-1:0] LAST_SYNC = SYNC_W'(SYNC_COUNT - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_SYNC,
    ST_ACTIVE
  } state_t;

  state_t            state, next_state;
  logic [2:0]        bit_cnt, next_bit_cnt;
  logic [SYNC_W-1:0] sync_cnt, next_sync_cnt;
  logic [7:0]        shift_0, next_shift_0;
  logic [7:0]        shift_1, next_shift_1;
  logic              boundary;
  logic [7:0]        lane_byte_0;
  logic [7:0]        lane_byte_1;

  // Byte offered on each lane at a boundary: the source byte when valid,
  // otherwise the filler symbol.
  always_comb begin
    lane_byte_0 = valid_in_0 ? data_in_0 : IDLE;
    lane_byte_1 = valid_in_1 ? data_in_1 : IDLE;
    boundary    = (bit_cnt == 3'd7);
  end

  // Next-state logic: sequencing of OFF -> SYNC burst -> ACTIVE, plus the
  // per-lane shifting and byte loading; ready is only ever raised when a
  // new byte is being taken from the source.
  always_comb begin
    next_state    = state;
    next_bit_cnt  = bit_cnt;
    next_sync_cnt = sync_cnt;
    next_shift_0  = shift_0;
    next_shift_1  = shift_1;
    ready         = 1'b0;

    case (state)
      ST_OFF: begin
        next_bit_cnt = 3'd0;
        next_shift_0 = 8'h00;
        next_shift_1 = 8'h00;
        if (enable) begin
          next_state    = ST_SYNC;
          next_sync_cnt = '0;
          next_shift_0  = COM;
          next_shift_1  = COM;
        end
      end

      ST_SYNC: begin
        next_bit_cnt = bit_cnt + 3'd1;
        next_shift_0 = {shift_0[6:0], 1'b0};
        next_shift_1 = {shift_1[6:0], 1'b0};
        if (boundary) begin
          next_sync_cnt = sync_cnt + SYNC_W'(1);
          if (!enable) begin
            next_state    = ST_OFF;
            next_sync_cnt = '0;
            next_shift_0  = 8'h00;
            next_shift_1  = 8'h00;
          end else if (sync_cnt == LAST_SYNC) begin
            next_state   = ST_ACTIVE;
            ready        = 1'b1;
            next_shift_0 = lane_byte_0;
            next_shift_1 = lane_byte_1;
          end else begin
            next_shift_0 = COM;
            next_shift_1 = COM;
          end
        end
      end

      ST_ACTIVE: begin
        next_bit_cnt = bit_cnt + 3'd1;
        next_shift_0 = {shift_0[6:0], 1'b0};
        next_shift_1 = {shift_1[6:0], 1'b0};
        if (boundary) begin
          if (!enable) begin
            next_state    = ST_OFF;
            next_sync_cnt = '0;
            next_shift_0  = 8'h00;
            next_shift_1  = 8'h00;
          end else begin
            ready        = 1'b1;
            next_shift_0 = lane_byte_0;
            next_shift_1 = lane_byte_1;
          end
        end
      end

      default: begin
        next_state    = ST_OFF;
        next_bit_cnt  = 3'd0;
        next_sync_cnt = '0;
        next_shift_0  = 8'h00;
        next_shift_1  = 8'h00;
      end
    endcase
  end

  // State register; reset abandons any partially sent byte immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_OFF;
      bit_cnt  <= 3'd0;
      sync_cnt <= '0;
      shift_0  <= 8'h00;
      shift_1  <= 8'h00;
    end else begin
      state    <= next_state;
      bit_cnt  <= next_bit_cnt;
      sync_cnt <= next_sync_cnt;
      shift_0  <= next_shift_0;
      shift_1  <= next_shift_1;
    end
  end

  // Serial lanes come straight from the shift register MSBs.
  always_comb begin
    D_0    = shift_0[7];
    D_1    = shift_1[7];
    active = (state == ST_ACTIVE);
  end

endmodule

// File: tb/tb_phy_tx.sv
// tb_phy_tx: directed bench for phy_tx with a queue-based bit-stream model.
module tb_phy_tx;

  localparam int         SYNC_COUNT = 4;
  localparam logic [7:0] COM        = 8'hBC;
  localparam logic [7:0] IDLE       = 8'h7C;

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic       enable     = 1'b0;
  logic [7:0] data_in_0  = 8'h00;
  logic       valid_in_0 = 1'b0;
  logic [7:0] data_in_1  = 8'h00;
  logic       valid_in_1 = 1'b0;
  logic       ready;
  logic       active;
  logic       D_0;
  logic       D_1;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Model: the bits still to appear on each lane, front = bit on the wire now.
  bit q0[$];
  bit q1[$];
  bit m_on      = 1'b0;
  int coms_left = 0;

  phy_tx #(
    .SYNC_COUNT(SYNC_COUNT),
    .COM       (COM),
    .IDLE      (IDLE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .data_in_0 (data_in_0),
    .valid_in_0(valid_in_0),
    .data_in_1 (data_in_1),
    .valid_in_1(valid_in_1),
    .ready     (ready),
    .active    (active),
    .D_0       (D_0),
    .D_1       (D_1)
  );

  // Free-running bit clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    chk_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 7; i >= 0; i--) begin
      q0.push_back(b0[i]);
      q1.push_back(b1[i]);
    end
  endtask

  // Model update: a byte ends when its last bit has been on the wire; what
  // follows depends on enable, the remaining COM count and the lane inputs.
  initial begin
    bit at_end;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        q0.delete();
        q1.delete();
        m_on      = 1'b0;
        coms_left = 0;
      end else if (!m_on) begin
        if (enable) begin
          m_on      = 1'b1;
          coms_left = SYNC_COUNT;
          push_byte(COM, COM);
        end
      end else begin
        at_end = (q0.size() == 1);
        void'(q0.pop_front());
        void'(q1.pop_front());
        if (at_end) begin
          if (!enable) begin
            m_on      = 1'b0;
            coms_left = 0;
          end else if (coms_left > 1) begin
            coms_left--;
            push_byte(COM, COM);
          end else begin
            coms_left = 0;
            push_byte(valid_in_0 ? data_in_0 : IDLE, valid_in_1 ? data_in_1 : IDLE);
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    logic exp_d0, exp_d1, exp_ready, exp_active;
    forever begin
      @(negedge clk);
      exp_d0     = (q0.size() > 0) ? q0[0] : 1'b0;
      exp_d1     = (q1.size() > 0) ? q1[0] : 1'b0;
      exp_ready  = m_on && (q0.size() == 1) && enable && (coms_left <= 1);
      exp_active = m_on && (coms_left == 0);
      check_output("D_0", {31'd0, D_0}, {31'd0, exp_d0});
      check_output("D_1", {31'd0, D_1}, {31'd0, exp_d1});
      check_output("ready", {31'd0, ready}, {31'd0, exp_ready});
      check_output("active", {31'd0, active}, {31'd0, exp_active});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enable from OFF and expect four COM bytes, ready on the 32nd bit cycle.
  task automatic sync_burst(input string name);
    logic [31:0] bits0, bits1;
    int n;
    bit seen;
    bits0  = '0;
    bits1  = '0;
    n      = 0;
    seen   = 1'b0;
    enable = 1'b1;
    while (!seen && n < 64) begin
      tick();
      n++;
      bits0 = {bits0[30:0], D_0};
      bits1 = {bits1[30:0], D_1};
      if (ready) seen = 1'b1;
    end
    check_output({name, "_ready_cycle"}, n, 32);
    check_output({name, "_lane0"}, bits0, 32'hBCBCBCBC);
    check_output({name, "_lane1"}, bits1, 32'hBCBCBCBC);
  endtask

  // Present a byte pair in a ready cycle and collect the eight serial bits.
  task automatic apply_stimulus(input string name, input logic [7:0] d0, input logic v0,
                                input logic [7:0] d1, input logic v1,
                                input logic [7:0] exp0, input logic [7:0] exp1);
    logic [7:0] b0, b1;
    b0 = '0;
    b1 = '0;
    data_in_0  = d0;
    valid_in_0 = v0;
    data_in_1  = d1;
    valid_in_1 = v1;
    for (int i = 0; i < 8; i++) begin
      tick();
      b0 = {b0[6:0], D_0};
      b1 = {b1[6:0], D_1};
      if (i == 0) check_output({name, "_active"}, {31'd0, active}, 32'd1);
    end
    check_output({name, "_lane0"}, {24'd0, b0}, {24'd0, exp0});
    check_output({name, "_lane1"}, {24'd0, b1}, {24'd0, exp1});
    check_output({name, "_next_ready"}, {31'd0, ready}, 32'd1);
  endtask

  // Directed sequence.
  initial begin
    logic       any_out;
    logic [7:0] b0, b1;

    // Reset, then idle with enable low.
    repeat (3) tick();
    reset   = 1'b1;
    any_out = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      any_out = any_out | D_0 | D_1 | ready | active;
    end
    check_output("idle_quiet", {31'd0, any_out}, 32'd0);

    // COM burst then data.
    sync_burst("sync1");
    apply_stimulus("data_a5_3c", 8'hA5, 1'b1, 8'h3C, 1'b1, 8'hA5, 8'h3C);
    apply_stimulus("fill_lane1", 8'hFF, 1'b1, 8'h12, 1'b0, 8'hFF, 8'h7C);
    for (int k = 0; k < 3; k++)
      apply_stimulus("idle_both", 8'h00, 1'b0, 8'h00, 1'b0, 8'h7C, 8'h7C);

    // Drop enable in the middle of a 0x55 byte.
    data_in_0  = 8'h55;
    valid_in_0 = 1'b1;
    data_in_1  = 8'h55;
    valid_in_1 = 1'b1;
    b0 = '0;
    b1 = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      b0 = {b0[6:0], D_0};
      b1 = {b1[6:0], D_1};
      if (i == 2) enable = 1'b0;
    end
    check_output("dis_lane0", {24'd0, b0}, 32'h55);
    check_output("dis_lane1", {24'd0, b1}, 32'h55);
    check_output("dis_no_ready", {31'd0, ready}, 32'd0);
    check_output("dis_last_active", {31'd0, active}, 32'd1);
    valid_in_0 = 1'b0;
    valid_in_1 = 1'b0;
    tick();
    check_output("dis_off_out", {29'd0, D_0, D_1, active}, 32'd0);
    repeat (5) tick();

    // Re-enable restarts the COM burst.
    sync_burst("sync2");

    // Async reset in the middle of an all-ones byte.
    data_in_0  = 8'hFF;
    valid_in_0 = 1'b1;
    data_in_1  = 8'hFF;
    valid_in_1 = 1'b1;
    repeat (4) tick();
    check_output("pre_reset_d", {30'd0, D_0, D_1}, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_reset_out", {28'd0, D_0, D_1, ready, active}, 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    sync_burst("sync3");
    apply_stimulus("post_reset", 8'h96, 1'b1, 8'h69, 1'b1, 8'h96, 8'h69);

    enable     = 1'b0;
    valid_in_0 = 1'b0;
    valid_in_1 = 1'b0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
